// File: rtl/divider_ctrl_pkg.sv
// Shared state encoding and default parameters for divider_ctrl.
package divider_ctrl_pkg;

  localparam int DEF_WIDTH = 15;
  localparam int DEF_DIV   = 5000;

  typedef enum logic [1:0] {
    STOP  = 2'd0,
    RUN   = 2'd1,
    PEND  = 2'd2,
    DRAIN = 2'd3
  } state_t;

endpackage

// File: rtl/divider_ctrl_div_core.sv
// div_core: period counter, terminal compare and divided clock/tick generation.
// Optional count_o output when DIVIDER_CTRL_COUNT_OUT_EN is defined.
module div_core
  import divider_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk_i,
  input  logic             reset_n,
  input  logic             run,
  input  logic             clear,
  input  logic [WIDTH-1:0] div_active,
  output logic             clk_o,
  output logic             tick_o,
  output logic             term
`ifdef DIVIDER_CTRL_COUNT_OUT_EN
  ,
  output logic [WIDTH-1:0] count_o
`endif
);

  logic [WIDTH-1:0] count;

  // Clearing at >= div_active keeps count from ever wrapping.
  assign term = run && (count >= div_active);

  // Counter and divided-clock registers; clear wins over a pending toggle.
  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      count  <= '0;
      clk_o  <= 1'b0;
      tick_o <= 1'b0;
    end else if (clear) begin
      count  <= '0;
      clk_o  <= 1'b0;
      tick_o <= 1'b0;
    end else if (term) begin
      count  <= '0;
      clk_o  <= ~clk_o;
      tick_o <= 1'b1;
    end else if (run) begin
      count  <= count + WIDTH'(1);
      tick_o <= 1'b0;
    end else begin
      tick_o <= 1'b0;
    end
  end

`ifdef DIVIDER_CTRL_COUNT_OUT_EN
  assign count_o = count;
`endif

endmodule

// File: rtl/divider_ctrl.sv
// divider_ctrl: programmable clock divider with glitch-free divisor handover.
// Define DIVIDER_CTRL_COUNT_OUT_EN to expose the internal counter on count_o.
module divider_ctrl
  import divider_ctrl_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int DEFAULT_DIV = DEF_DIV
) (
  input  logic             clk_i,
  input  logic             reset_n,
  input  logic             enable_i,
  input  logic [WIDTH-1:0] div_i,
  input  logic             div_valid_i,
  output logic             div_ready_o,
  output logic             clk_o,
  output logic             tick_o,
  output logic             busy_o
`ifdef DIVIDER_CTRL_COUNT_OUT_EN
  ,
  output logic [WIDTH-1:0] count_o
`endif
);

  localparam logic [WIDTH-1:0] RESET_DIV = WIDTH'(DEFAULT_DIV);

  state_t           state, next_state;
  logic [WIDTH-1:0] div_active, active_next;
  logic [WIDTH-1:0] div_pend, pend_next;
  logic             have_pend, have_pend_next;
  logic             run, clear, term, xfer, fall;

  assign run  = (state != STOP);
  assign xfer = div_valid_i && div_ready_o;
  assign fall = term && clk_o;

  div_core #(.WIDTH(WIDTH)) u_core (
    .clk_i      (clk_i),
    .reset_n    (reset_n),
    .run        (run),
    .clear      (clear),
    .div_active (div_active),
    .clk_o      (clk_o),
    .tick_o     (tick_o),
    .term       (term)
`ifdef DIVIDER_CTRL_COUNT_OUT_EN
    ,
    .count_o    (count_o)
`endif
  );

  // Next-state, counter clear and divisor update decisions.
  always_comb begin
    next_state     = state;
    clear          = 1'b0;
    active_next    = div_active;
    pend_next      = div_pend;
    have_pend_next = have_pend;
    case (state)
      STOP: begin
        clear       = 1'b1;
        active_next = xfer ? div_i : div_active;
        next_state  = enable_i ? RUN : STOP;
      end
      RUN: begin
        // A stop that coincides with the falling toggle needs no drain phase.
        if (!enable_i && (!clk_o || fall)) begin
          next_state  = STOP;
          clear       = !clk_o;
          active_next = xfer ? div_i : div_active;
        end else if (!enable_i) begin
          next_state = DRAIN;
          if (xfer) begin
            pend_next      = div_i;
            have_pend_next = 1'b1;
          end else begin
            have_pend_next = have_pend;
          end
        end else if (xfer) begin
          next_state     = PEND;
          pend_next      = div_i;
          have_pend_next = 1'b1;
        end else begin
          next_state = RUN;
        end
      end
      PEND: begin
        if (!enable_i && (!clk_o || fall)) begin
          next_state     = STOP;
          clear          = !clk_o;
          active_next    = div_pend;
          have_pend_next = 1'b0;
        end else if (!enable_i) begin
          next_state = DRAIN;
        end else if (fall) begin
          next_state     = RUN;
          active_next    = div_pend;
          have_pend_next = 1'b0;
        end else begin
          next_state = PEND;
        end
      end
      DRAIN: begin
        if (fall) begin
          next_state     = STOP;
          active_next    = have_pend ? div_pend : div_active;
          have_pend_next = 1'b0;
        end else begin
          next_state = DRAIN;
        end
      end
      default: begin
        next_state = STOP;
        clear      = 1'b1;
      end
    endcase
  end

  // State, divisor registers and registered handshake/status outputs.
  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      state       <= STOP;
      div_active  <= RESET_DIV;
      div_pend    <= '0;
      have_pend   <= 1'b0;
      div_ready_o <= 1'b1;
      busy_o      <= 1'b0;
    end else begin
      state       <= next_state;
      div_active  <= active_next;
      div_pend    <= pend_next;
      have_pend   <= have_pend_next;
      div_ready_o <= (next_state == STOP) || (next_state == RUN);
      busy_o      <= (next_state != STOP);
    end
  end

endmodule

// File: tb/tb_divider_ctrl.sv
// Self-checking bench for divider_ctrl: table-driven divisor runs plus
// hand-written handover, drain and reset sequences, checked via an edge scoreboard.
module tb_divider_ctrl;

  localparam int W = 15;

  logic         clk_i = 1'b0;
  logic         reset_n;
  logic         enable_i;
  logic [W-1:0] div_i;
  logic         div_valid_i;
  logic         div_ready_o;
  logic         clk_o;
  logic         tick_o;
  logic         busy_o;
`ifdef DIVIDER_CTRL_COUNT_OUT_EN
  logic [W-1:0] count_o;
`endif

  divider_ctrl dut (
    .clk_i       (clk_i),
    .reset_n     (reset_n),
    .enable_i    (enable_i),
    .div_i       (div_i),
    .div_valid_i (div_valid_i),
    .div_ready_o (div_ready_o),
    .clk_o       (clk_o),
    .tick_o      (tick_o),
    .busy_o      (busy_o)
`ifdef DIVIDER_CTRL_COUNT_OUT_EN
    ,
    .count_o     (count_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int div;
    int edges;
    int half;
    int clk_after;
  } vec_t;

  vec_t vecs[5];
  int   exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   last_edge = 0;
  logic prev_clk = 1'b0;
  logic prev_busy = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk_i);
      #1;
    end
  endtask

  task automatic wait_empty(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) step(1);
    check("sb_drain", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic push_n(input int n, input int half);
    for (int i = 0; i < n; i++) exp_q.push_back(half);
  endtask

  task automatic write_div(input int d);
    div_i       = W'(d);
    div_valid_i = 1'b1;
    step(1);
    div_valid_i = 1'b0;
  endtask

  always @(posedge clk_i) cyc = cyc + 1;

  // Edge monitor: tick must mark exactly the clk_o transitions, and each
  // transition's spacing is popped from the scoreboard.
  always @(negedge clk_i) begin
    if (!reset_n) begin
      prev_clk  = 1'b0;
      prev_busy = 1'b0;
    end else begin
      check("tick", int'(tick_o), int'(clk_o != prev_clk));
      if (busy_o && !prev_busy) last_edge = cyc;
      if (clk_o != prev_clk) begin
        if (exp_q.size() == 0) check("unexpected_edge", int'(clk_o), int'(prev_clk));
        else check("interval", cyc - last_edge, exp_q.pop_front());
        last_edge = cyc;
      end
      prev_clk  = clk_o;
      prev_busy = busy_o;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{3, 4, 4, 0};
    vecs[1] = '{5, 3, 6, 1};
    vecs[2] = '{0, 6, 1, 0};
    vecs[3] = '{1, 5, 2, 1};
    vecs[4] = '{7, 2, 8, 0};

    reset_n     = 1'b0;
    enable_i    = 1'b0;
    div_valid_i = 1'b0;
    div_i       = '0;
    step(3);
    check("rst_clk", int'(clk_o), 0);
    check("rst_tick", int'(tick_o), 0);
    check("rst_busy", int'(busy_o), 0);
    check("rst_ready", int'(div_ready_o), 1);
    reset_n = 1'b1;
    step(2);

    // Default divisor: half period 5001, full period 10002.
    push_n(3, 5001);
    enable_i = 1'b1;
    wait_empty(15100);
    check("def_clk_high", int'(clk_o), 1);
    check("def_busy", int'(busy_o), 1);
    push_n(1, 5001);
    enable_i = 1'b0;
    wait_empty(5100);
    step(3);
    check("def_stop_busy", int'(busy_o), 0);

    foreach (vecs[k]) begin
      write_div(vecs[k].div);
      check("stop_ready", int'(div_ready_o), 1);
      check("stop_busy", int'(busy_o), 0);
      push_n(vecs[k].edges, vecs[k].half);
      enable_i = 1'b1;
      wait_empty(vecs[k].half * vecs[k].edges + 10);
      check("run_clk", int'(clk_o), vecs[k].clk_after);
      check("run_busy", int'(busy_o), 1);
      if (vecs[k].clk_after == 1) push_n(1, vecs[k].half);
      enable_i = 1'b0;
      wait_empty(vecs[k].half + 10);
      step(3);
      check("end_busy", int'(busy_o), 0);
      check("end_clk", int'(clk_o), 0);
      check("end_ready", int'(div_ready_o), 1);
      step(2 * vecs[k].half + 4);
    end

    // Divisor change 9 -> 2 during the high phase.
    write_div(9);
    push_n(1, 10);
    enable_i = 1'b1;
    wait_empty(30);
    check("hs_clk_high", int'(clk_o), 1);
    exp_q.push_back(10);
    push_n(3, 3);
    write_div(2);
    check("hs_ready_low", int'(div_ready_o), 0);
    wait_empty(40);
    check("hs_ready_back", int'(div_ready_o), 1);
    push_n(1, 3);
    enable_i = 1'b0;
    wait_empty(20);
    step(3);
    check("hs_stop_busy", int'(busy_o), 0);

    // Reset while a divisor is pending mid-period.
    write_div(9);
    push_n(1, 10);
    enable_i = 1'b1;
    wait_empty(30);
    write_div(2);
    check("rp_ready_low", int'(div_ready_o), 0);
    step(3);
    reset_n = 1'b0;
    #1;
    check("rp_clk", int'(clk_o), 0);
    check("rp_tick", int'(tick_o), 0);
    check("rp_busy", int'(busy_o), 0);
    check("rp_ready", int'(div_ready_o), 1);
    enable_i = 1'b0;
    step(2);
    reset_n = 1'b1;
    step(2);
    push_n(1, 5001);
    enable_i = 1'b1;
    wait_empty(5100);
    check("rp_clk_high", int'(clk_o), 1);
    push_n(1, 5001);
    enable_i = 1'b0;
    wait_empty(5100);
    step(3);
    check("rp_stop_busy", int'(busy_o), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
